// File: rtl/move_undo_stack_pkg.sv
// Shared move-entry layout, FSM encoding and sel encode/decode helpers for the undo stack.
package move_undo_stack_pkg;

  localparam int unsigned MOVE_W  = 4;
  localparam int unsigned NROW_B  = 3;
  localparam int unsigned SEL_LSB = 1;
  localparam int unsigned ADDN_B  = 0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_POP   = 3'd1,
    ST_ISSUE = 3'd2,
    ST_GAP   = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  function automatic logic [1:0] onehot_to_idx(input logic [3:0] sel);
    logic [1:0] idx;
    idx = 2'd0;
    case (sel)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  function automatic logic [3:0] idx_to_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  function automatic logic [MOVE_W-1:0] pack_move(input logic nrow, input logic [3:0] sel,
                                                  input logic addn);
    logic [MOVE_W-1:0] m;
    m = '0;
    m[NROW_B]          = nrow;
    m[SEL_LSB +: 2]    = onehot_to_idx(sel);
    m[ADDN_B]          = addn;
    return m;
  endfunction

endpackage

// File: rtl/move_ring_buffer.sv
// Circular move store: synchronous write on push, synchronous read of the newest entry on pop.
module move_ring_buffer
  import move_undo_stack_pkg::*;
#(
  parameter  int unsigned DEPTH = 32,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic [MOVE_W-1:0] wdata_i,
  input  logic              pop_i,
  output logic [MOVE_W-1:0] rdata_o,
  output logic [CW-1:0]     count_o
);

  logic [MOVE_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wp_q;
  logic [CW-1:0]     count_q;
  logic [MOVE_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wp_q] <= wdata_i;
  end

  // A push at full capacity overwrites the oldest slot, so count saturates at DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q    <= '0;
      count_q <= '0;
      rdata_q <= '0;
    end else if (push_i) begin
      wp_q <= wp_q + AW'(1);
      if (count_q != CW'(DEPTH)) count_q <= count_q + CW'(1);
    end else if (pop_i) begin
      rdata_q <= mem_q[wp_q - AW'(1)];
      wp_q    <= wp_q - AW'(1);
      if (count_q != '0) count_q <= count_q - CW'(1);
    end
  end

  assign rdata_o = rdata_q;
  assign count_o = count_q;

endmodule

// File: rtl/move_undo_stack.sv
// Records grid moves and replays them newest-first with inverted direction.
// Optional feature macro: UNDO_SINGLE_STEP_EN (adds step_i; replay advances only on step pulses).
module move_undo_stack
  import move_undo_stack_pkg::*;
#(
  parameter  int unsigned DEPTH    = 32,
  parameter  int unsigned FIRE_GAP = 16,
  localparam int unsigned CW       = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rec_valid_i,
  input  logic          rec_nrow_i,
  input  logic [3:0]    rec_sel_i,
  input  logic          rec_addn_i,
  input  logic          undo_start_i,
`ifdef UNDO_SINGLE_STEP_EN
  input  logic          step_i,
`endif
  output logic          out_fire_o,
  output logic          out_nrow_o,
  output logic [3:0]    out_sel_o,
  output logic          out_addn_o,
  output logic          busy_o,
  output logic          done_o,
  output logic [CW-1:0] count_o,
  output logic          lost_o
);

  localparam int unsigned GW = $clog2(FIRE_GAP + 1);
  localparam logic [GW-1:0] GAP_POP  = GW'(FIRE_GAP - 2);
  localparam logic [GW-1:0] GAP_DONE = GW'(FIRE_GAP - 1);
`ifdef UNDO_SINGLE_STEP_EN
  localparam logic [GW-1:0] GAP_SAT  = GW'(FIRE_GAP);
`else
  localparam logic [GW-1:0] GAP_SAT  = GAP_DONE;
`endif

  state_e            state_q;
  logic [GW-1:0]     gap_q;
  logic              fire_q, nrow_q, addn_q, busy_q, done_q, lost_q;
  logic [3:0]        sel_q;
  logic [MOVE_W-1:0] rdata;
  logic [CW-1:0]     count;
  logic              push_ok_c, pop_c, full_c, gap_exit_c;

  always_comb begin
    push_ok_c = (state_q == ST_IDLE) && rec_valid_i && $onehot(rec_sel_i);
    pop_c     = (state_q == ST_POP);
    full_c    = (count == CW'(DEPTH));
`ifdef UNDO_SINGLE_STEP_EN
    gap_exit_c = step_i && (gap_q >= GAP_SAT);
`else
    // Leaving for POP takes two more cycles to fire; leaving for DONE takes one to pulse done.
    gap_exit_c = (count != '0) ? (gap_q == GAP_POP) : (gap_q == GAP_DONE);
`endif
  end

  move_ring_buffer #(.DEPTH(DEPTH)) u_ring (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_ok_c),
    .wdata_i (pack_move(rec_nrow_i, rec_sel_i, rec_addn_i)),
    .pop_i   (pop_c),
    .rdata_o (rdata),
    .count_o (count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      gap_q   <= '0;
      fire_q  <= 1'b0;
      nrow_q  <= 1'b0;
      sel_q   <= 4'b0000;
      addn_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      lost_q  <= 1'b0;
    end else begin
      fire_q <= 1'b0;
      done_q <= 1'b0;
      if (push_ok_c && full_c) lost_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (undo_start_i) begin
            busy_q  <= 1'b1;
            state_q <= (count != '0 || push_ok_c) ? ST_POP : ST_DONE;
          end
        end
        ST_POP:   state_q <= ST_ISSUE;
        ST_ISSUE: begin
          fire_q  <= 1'b1;
          nrow_q  <= rdata[NROW_B];
          sel_q   <= idx_to_onehot(rdata[SEL_LSB +: 2]);
          addn_q  <= ~rdata[ADDN_B];
          gap_q   <= GW'(1);
          state_q <= ST_GAP;
        end
        ST_GAP: begin
          if (gap_exit_c)          state_q <= (count != '0) ? ST_POP : ST_DONE;
          else if (gap_q != GAP_SAT) gap_q <= gap_q + GW'(1);
        end
        ST_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          sel_q   <= 4'b0000;
          lost_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out_fire_o = fire_q;
  assign out_nrow_o = nrow_q;
  assign out_sel_o  = sel_q;
  assign out_addn_o = addn_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign count_o    = count;
  assign lost_o     = lost_q;

endmodule

// File: tb/tb_move_undo_stack.sv
// Directed bench: default-size stack (A) plus a DEPTH=4, FIRE_GAP=3 stack (B) for overwrite behaviour.
module tb_move_undo_stack;

  localparam int unsigned A_DEPTH = 32;
  localparam int unsigned A_GAP   = 16;
  localparam int unsigned B_DEPTH = 4;
  localparam int unsigned B_GAP   = 3;
`ifdef UNDO_SINGLE_STEP_EN
  localparam int A_FG = A_GAP + 2, A_FD = A_GAP + 1;
  localparam int B_FG = B_GAP + 2, B_FD = B_GAP + 1;
`else
  localparam int A_FG = A_GAP, A_FD = A_GAP;
  localparam int B_FG = B_GAP, B_FD = B_GAP;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic a_rec_valid, a_rec_nrow, a_rec_addn, a_undo;
  logic [3:0] a_rec_sel;
  logic a_fire, a_nrow, a_addn, a_busy, a_done, a_lost;
  logic [3:0] a_sel;
  logic [5:0] a_count;
  logic b_rec_valid, b_rec_nrow, b_rec_addn, b_undo;
  logic [3:0] b_rec_sel;
  logic b_fire, b_nrow, b_addn, b_busy, b_done, b_lost;
  logic [3:0] b_sel;
  logic [2:0] b_count;
`ifdef UNDO_SINGLE_STEP_EN
  logic a_step, b_step;
`endif

  move_undo_stack #(.DEPTH(A_DEPTH), .FIRE_GAP(A_GAP)) dut_a (
    .clk(clk), .reset(reset), .rec_valid_i(a_rec_valid), .rec_nrow_i(a_rec_nrow),
    .rec_sel_i(a_rec_sel), .rec_addn_i(a_rec_addn), .undo_start_i(a_undo),
`ifdef UNDO_SINGLE_STEP_EN
    .step_i(a_step),
`endif
    .out_fire_o(a_fire), .out_nrow_o(a_nrow), .out_sel_o(a_sel), .out_addn_o(a_addn),
    .busy_o(a_busy), .done_o(a_done), .count_o(a_count), .lost_o(a_lost)
  );

  move_undo_stack #(.DEPTH(B_DEPTH), .FIRE_GAP(B_GAP)) dut_b (
    .clk(clk), .reset(reset), .rec_valid_i(b_rec_valid), .rec_nrow_i(b_rec_nrow),
    .rec_sel_i(b_rec_sel), .rec_addn_i(b_rec_addn), .undo_start_i(b_undo),
`ifdef UNDO_SINGLE_STEP_EN
    .step_i(b_step),
`endif
    .out_fire_o(b_fire), .out_nrow_o(b_nrow), .out_sel_o(b_sel), .out_addn_o(b_addn),
    .busy_o(b_busy), .done_o(b_done), .count_o(b_count), .lost_o(b_lost)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int         cap_cyc  [8];
  logic       cap_nrow [8];
  logic [3:0] cap_sel  [8];
  logic       cap_addn [8];
  int         cap_n;
  int         cap_done;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    a_rec_valid = 0; a_rec_nrow = 0; a_rec_sel = 0; a_rec_addn = 0; a_undo = 0;
    b_rec_valid = 0; b_rec_nrow = 0; b_rec_sel = 0; b_rec_addn = 0; b_undo = 0;
`ifdef UNDO_SINGLE_STEP_EN
    a_step = 1'b1; b_step = 1'b1;
`endif
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic push_a(input logic nrow, input logic [3:0] sel, input logic addn);
    a_rec_valid = 1'b1; a_rec_nrow = nrow; a_rec_sel = sel; a_rec_addn = addn;
    tick();
    a_rec_valid = 1'b0;
  endtask

  task automatic push_b(input logic nrow, input logic [3:0] sel, input logic addn);
    b_rec_valid = 1'b1; b_rec_nrow = nrow; b_rec_sel = sel; b_rec_addn = addn;
    tick();
    b_rec_valid = 1'b0;
  endtask

  // Cycle i is the sample taken i edges after the edge that sampled undo_start.
  task automatic capture(input bit which, input bit disturb, input bit step_mode, input int budget);
    logic f, d, n, ad;
    logic [3:0] s;
    cap_n = 0;
    cap_done = -1;
    for (int k = 0; k < 8; k++) begin
      cap_cyc[k] = -1; cap_nrow[k] = 1'bx; cap_sel[k] = 4'bxxxx; cap_addn[k] = 1'bx;
    end
    for (int i = 1; i <= budget && cap_done < 0; i++) begin
      if (!which) begin
        a_rec_valid = disturb && (i == 5 || i == 20);
        a_rec_nrow = 1'b1; a_rec_sel = 4'b0010; a_rec_addn = 1'b0;
        a_undo = disturb && (i == 10);
`ifdef UNDO_SINGLE_STEP_EN
        if (step_mode) a_step = (i == A_GAP + 1) || (i == A_GAP + 2) || (i == 2 * A_GAP + 4);
`endif
      end
      tick();
      f  = which ? b_fire : a_fire;
      d  = which ? b_done : a_done;
      n  = which ? b_nrow : a_nrow;
      s  = which ? b_sel  : a_sel;
      ad = which ? b_addn : a_addn;
      if (f && cap_n < 8) begin
        cap_cyc[cap_n] = i; cap_nrow[cap_n] = n; cap_sel[cap_n] = s; cap_addn[cap_n] = ad;
        cap_n++;
      end
      if (d) cap_done = i;
    end
    a_rec_valid = 1'b0; a_undo = 1'b0;
    if (step_mode) ;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({a_fire, a_nrow, a_sel, a_addn, a_busy, a_done, a_lost} !== 10'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %b expected 0",
                         {a_fire, a_nrow, a_sel, a_addn, a_busy, a_done, a_lost});
    end
    n_checks++;
    if (a_count !== 6'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", a_count); end
  endtask

  task automatic test_basic();
    logic       en [3] = '{1'b0, 1'b1, 1'b0};
    logic [3:0] es [3] = '{4'b1000, 4'b0100, 4'b0001};
    logic       ea [3] = '{1'b0, 1'b1, 1'b1};
    do_reset();
    push_a(1'b0, 4'b0001, 1'b0);
    push_a(1'b1, 4'b0100, 1'b0);
    push_a(1'b0, 4'b1000, 1'b1);
    push_a(1'b0, 4'b0011, 1'b0);
    n_checks++;
    if (a_count !== 6'd3) begin n_fail++; $display("FAIL basic_count: got %0d expected 3", a_count); end
    a_undo = 1'b1; tick(); a_undo = 1'b0;
    n_checks++;
    if (a_busy !== 1'b1 || a_fire !== 1'b0) begin
      n_fail++; $display("FAIL basic_busy_start: busy=%b fire=%b expected busy=1 fire=0", a_busy, a_fire);
    end
    capture(1'b0, 1'b0, 1'b0, 200);
    n_checks++;
    if (cap_n !== 3) begin n_fail++; $display("FAIL basic_nfire: got %0d expected 3", cap_n); end
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (cap_cyc[k] !== 2 + k * A_FG) begin
        n_fail++; $display("FAIL basic_fire_time[%0d]: got %0d expected %0d", k, cap_cyc[k], 2 + k * A_FG);
      end
      n_checks++;
      if (cap_nrow[k] !== en[k] || cap_sel[k] !== es[k] || cap_addn[k] !== ea[k]) begin
        n_fail++; $display("FAIL basic_move[%0d]: got %b/%b/%b expected %b/%b/%b", k,
                           cap_nrow[k], cap_sel[k], cap_addn[k], en[k], es[k], ea[k]);
      end
    end
    n_checks++;
    if (cap_done !== 2 + 2 * A_FG + A_FD) begin
      n_fail++; $display("FAIL basic_done_time: got %0d expected %0d", cap_done, 2 + 2 * A_FG + A_FD);
    end
    n_checks++;
    if (a_count !== 6'd0 || a_busy !== 1'b0 || a_sel !== 4'b0000) begin
      n_fail++; $display("FAIL basic_end_state: count=%0d busy=%b sel=%b expected 0/0/0000",
                         a_count, a_busy, a_sel);
    end
  endtask

  task automatic test_empty();
    do_reset();
    a_undo = 1'b1; tick(); a_undo = 1'b0;
    n_checks++;
    if (a_busy !== 1'b1 || a_done !== 1'b0) begin
      n_fail++; $display("FAIL empty_cycle1: busy=%b done=%b expected 1/0", a_busy, a_done);
    end
    tick();
    n_checks++;
    if (a_busy !== 1'b0 || a_done !== 1'b1 || a_fire !== 1'b0) begin
      n_fail++; $display("FAIL empty_cycle2: busy=%b done=%b fire=%b expected 0/1/0", a_busy, a_done, a_fire);
    end
    tick();
    n_checks++;
    if (a_done !== 1'b0 || a_count !== 6'd0) begin
      n_fail++; $display("FAIL empty_after: done=%b count=%0d expected 0/0", a_done, a_count);
    end
  endtask

  task automatic test_depth_overwrite();
    logic       en [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [3:0] es [4] = '{4'b0010, 4'b0001, 4'b1000, 4'b0100};
    logic       ea [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    do_reset();
    push_b(1'b0, 4'b0001, 1'b0);
    push_b(1'b0, 4'b0010, 1'b0);
    push_b(1'b0, 4'b0100, 1'b0);
    push_b(1'b0, 4'b1000, 1'b0);
    push_b(1'b1, 4'b0001, 1'b0);
    push_b(1'b1, 4'b0010, 1'b1);
    n_checks++;
    if (b_count !== 3'd4 || b_lost !== 1'b1) begin
      n_fail++; $display("FAIL depth_full: count=%0d lost=%b expected 4/1", b_count, b_lost);
    end
    b_undo = 1'b1; tick(); b_undo = 1'b0;
    capture(1'b1, 1'b0, 1'b0, 100);
    n_checks++;
    if (cap_n !== 4) begin n_fail++; $display("FAIL depth_nfire: got %0d expected 4", cap_n); end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (cap_cyc[k] !== 2 + k * B_FG || cap_nrow[k] !== en[k] || cap_sel[k] !== es[k] ||
          cap_addn[k] !== ea[k]) begin
        n_fail++; $display("FAIL depth_move[%0d]: got t=%0d %b/%b/%b expected t=%0d %b/%b/%b", k,
                           cap_cyc[k], cap_nrow[k], cap_sel[k], cap_addn[k], 2 + k * B_FG,
                           en[k], es[k], ea[k]);
      end
    end
    n_checks++;
    if (cap_done !== 2 + 3 * B_FG + B_FD || b_lost !== 1'b0 || b_count !== 3'd0) begin
      n_fail++; $display("FAIL depth_done: t=%0d lost=%b count=%0d expected t=%0d 0/0",
                         cap_done, b_lost, b_count, 2 + 3 * B_FG + B_FD);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    a_rec_valid = 1'b1; a_rec_nrow = 1'b1; a_rec_sel = 4'b0010; a_rec_addn = 1'b0;
    a_undo = 1'b1;
    tick();
    a_rec_valid = 1'b0; a_undo = 1'b0;
    n_checks++;
    if (a_count !== 6'd1 || a_busy !== 1'b1) begin
      n_fail++; $display("FAIL b2b_push: count=%0d busy=%b expected 1/1", a_count, a_busy);
    end
    capture(1'b0, 1'b0, 1'b0, 100);
    n_checks++;
    if (cap_n !== 1 || cap_cyc[0] !== 2 || cap_nrow[0] !== 1'b1 || cap_sel[0] !== 4'b0010 ||
        cap_addn[0] !== 1'b1) begin
      n_fail++; $display("FAIL b2b_move: n=%0d t=%0d %b/%b/%b expected 1 t=2 1/0010/1",
                         cap_n, cap_cyc[0], cap_nrow[0], cap_sel[0], cap_addn[0]);
    end
    n_checks++;
    if (cap_done !== 2 + A_FD || a_count !== 6'd0) begin
      n_fail++; $display("FAIL b2b_done: t=%0d count=%0d expected t=%0d 0", cap_done, a_count, 2 + A_FD);
    end
  endtask

  task automatic test_ignore_while_busy();
    do_reset();
    push_a(1'b0, 4'b0001, 1'b0);
    push_a(1'b1, 4'b1000, 1'b1);
    a_undo = 1'b1; tick(); a_undo = 1'b0;
    capture(1'b0, 1'b1, 1'b0, 200);
    n_checks++;
    if (cap_n !== 2 || cap_cyc[0] !== 2 || cap_cyc[1] !== 2 + A_FG) begin
      n_fail++; $display("FAIL busy_fire_times: n=%0d t0=%0d t1=%0d expected 2 2 %0d",
                         cap_n, cap_cyc[0], cap_cyc[1], 2 + A_FG);
    end
    n_checks++;
    if (cap_nrow[0] !== 1'b1 || cap_sel[0] !== 4'b1000 || cap_addn[0] !== 1'b0 ||
        cap_nrow[1] !== 1'b0 || cap_sel[1] !== 4'b0001 || cap_addn[1] !== 1'b1) begin
      n_fail++; $display("FAIL busy_moves: got %b/%b/%b %b/%b/%b expected 1/1000/0 0/0001/1",
                         cap_nrow[0], cap_sel[0], cap_addn[0], cap_nrow[1], cap_sel[1], cap_addn[1]);
    end
    n_checks++;
    if (cap_done !== 2 + A_FG + A_FD || a_count !== 6'd0) begin
      n_fail++; $display("FAIL busy_done: t=%0d count=%0d expected t=%0d 0",
                         cap_done, a_count, 2 + A_FG + A_FD);
    end
  endtask

  task automatic test_reset_mid_replay();
    bit seen_fire;
    bit seen;
    do_reset();
    push_a(1'b0, 4'b0001, 1'b0);
    push_a(1'b1, 4'b0100, 1'b0);
    a_undo = 1'b1; tick(); a_undo = 1'b0;
    seen_fire = 1'b0;
    for (int i = 0; i < 10 && !seen_fire; i++) begin
      tick();
      seen_fire = a_fire;
    end
    n_checks++;
    if (!seen_fire || a_nrow !== 1'b1 || a_addn !== 1'b1) begin
      n_fail++; $display("FAIL midrst_first_fire: seen=%0d nrow=%b addn=%b expected 1/1/1",
                         seen_fire, a_nrow, a_addn);
    end
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    n_checks++;
    if ({a_fire, a_nrow, a_sel, a_addn, a_busy, a_done, a_lost} !== 10'd0 || a_count !== 6'd0) begin
      n_fail++; $display("FAIL midrst_outputs: got %b count=%0d expected 0 count=0",
                         {a_fire, a_nrow, a_sel, a_addn, a_busy, a_done, a_lost}, a_count);
    end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (a_done || a_fire) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL midrst_no_done: got activity=%0d expected 0", seen); end
  endtask

`ifdef UNDO_SINGLE_STEP_EN
  task automatic test_step();
    do_reset();
    a_step = 1'b0;
    push_a(1'b0, 4'b0001, 1'b0);
    push_a(1'b1, 4'b0100, 1'b0);
    a_undo = 1'b1; tick(); a_undo = 1'b0;
    capture(1'b0, 1'b0, 1'b1, 100);
    n_checks++;
    if (cap_n !== 2 || cap_cyc[0] !== 2 || cap_cyc[1] !== A_GAP + 4) begin
      n_fail++; $display("FAIL step_fires: n=%0d t0=%0d t1=%0d expected 2 2 %0d",
                         cap_n, cap_cyc[0], cap_cyc[1], A_GAP + 4);
    end
    n_checks++;
    if (cap_done !== 2 * A_GAP + 5) begin
      n_fail++; $display("FAIL step_done: t=%0d expected %0d", cap_done, 2 * A_GAP + 5);
    end
    a_step = 1'b1;
  endtask
`endif

  initial begin
    reset = 1'b1;
    test_reset();
    test_basic();
    test_empty();
    test_depth_overwrite();
    test_back_to_back();
    test_ignore_while_busy();
    test_reset_mid_replay();
`ifdef UNDO_SINGLE_STEP_EN
    test_step();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
